// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity (UART_TX_PARITY_EN), STOP_BITS stop bits.
// Latency: start bit begins on the first baud tick after acceptance; every bit lasts one baud_clk period.
// Backpressure: tx_ready is high only while idle; tx_valid/tx_data are ignored while busy.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t     state;
    logic       baud_d;
    logic       tick;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
`ifdef UART_TX_PARITY_EN
    logic       parity_bit;
`endif

    assign tick = baud_clk & ~baud_d;
    assign busy = ~tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_d     <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            baud_d  <= baud_clk;
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ready rises one cycle after the tx_done pulse
                    if (!tx_ready) begin
                        tx_ready <= 1'b1;
                    end else if (tx_valid) begin
                        shreg      <= tx_data & DATA_MASK;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^(tx_data & DATA_MASK)) ^ PARITY_ODD;
`endif
                        tx_ready   <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx       <= parity_bit;
                            state    <= S_PARITY;
`else
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (8N1 and 7-bit/2-stop), random bytes checked against a bit-list frame model.
module tb_uart_tx;

    localparam int D = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_clk = 1'b0;
    logic [7:0] tx_data [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic       tx [2];
    logic       busy [2];
    logic       tx_done [2];

    int db [2] = '{8, 7};
    int sb [2] = '{1, 2};
    bit odd [2] = '{1'b0, 1'b1};

    int total = 0;
    int bad = 0;

    logic exp_wave [$];
    logic cap_tx [$];
    logic cap_done [$];
    logic cap_rdy [$];

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b0)
`endif
    ) u0 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
    );

    uart_tx #(.DATA_BITS(7), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(1'b1)
`endif
    ) u1 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
    );

    always #10 clk = ~clk;

    initial begin
        forever begin
            repeat (D / 2) @(negedge clk);
            baud_clk = ~baud_clk;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
        $fatal(1);
    end

    function automatic int frame_len(input int s);
        return 1 + db[s] + int'(PAR_EN) + sb[s];
    endfunction

    task automatic push_bit(input logic b);
        repeat (D) exp_wave.push_back(b);
    endtask

    // A frame as the list of line levels it should produce, one entry per clk.
    task automatic model_frame(input int s, input logic [7:0] d);
        logic [7:0] m;
        m = d & (8'hFF >> (8 - db[s]));
        push_bit(1'b0);
        for (int i = 0; i < db[s]; i++) push_bit(m[i]);
        if (PAR_EN) push_bit((($countones(m) % 2) == 1) ^ odd[s]);
        for (int i = 0; i < sb[s]; i++) push_bit(1'b1);
    endtask

    task automatic capture(input int s, input int nsamp, output bit found);
        cap_tx.delete();
        cap_done.delete();
        cap_rdy.delete();
        found = 1'b0;
        for (int i = 0; i < 4 * D && !found; i++) begin
            @(negedge clk);
            if (tx[s] === 1'b0) found = 1'b1;
        end
        if (found) begin
            for (int i = 0; i < nsamp; i++) begin
                if (i > 0) @(negedge clk);
                cap_tx.push_back(tx[s]);
                cap_done.push_back(tx_done[s]);
                cap_rdy.push_back(tx_ready[s]);
            end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_wave.size(); i++)
            if (i >= cap_tx.size() || cap_tx[i] !== exp_wave[i]) return i;
        return -1;
    endfunction

    task automatic start_byte(input int s, input logic [7:0] d);
        @(negedge clk);
        tx_data[s]  = d;
        tx_valid[s] = 1'b1;
        @(negedge clk);
        tx_valid[s] = 1'b0;
        tx_data[s]  = 8'($urandom);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            total++;
            if (tx[s] !== 1'b1 || tx_ready[s] !== 1'b1 || busy[s] !== 1'b0 || tx_done[s] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state[%0d]: tx=%b ready=%b busy=%b done=%b, need 1 1 0 0",
                         s, tx[s], tx_ready[s], busy[s], tx_done[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * D) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (tx[s] !== 1'b1 || tx_ready[s] !== 1'b1) begin
                bad++;
                $display("FAIL idle_after_reset[%0d]: tx=%b ready=%b, need 1 1", s, tx[s], tx_ready[s]);
            end
        end
    endtask

    task automatic test_frame(input int s, input logic [7:0] d);
        bit found;
        int n, idx, npulse, pos;
        n = frame_len(s);
        start_byte(s, d);
        capture(s, n * D + 4, found);
        total++;
        if (!found) begin
            bad++;
            $display("FAIL frame_start[%0d] data=%h: no start bit within %0d cycles", s, d, 4 * D);
        end else begin
            exp_wave.delete();
            model_frame(s, d);
            idx = first_diff();
            if (idx != -1) begin
                bad++;
                $display("FAIL frame_bits[%0d] data=%h: sample %0d (bit %0d) tx=%b, need %b",
                         s, d, idx, idx / D, cap_tx[idx], exp_wave[idx]);
            end
            npulse = 0;
            pos = -1;
            for (int i = 0; i < cap_done.size(); i++)
                if (cap_done[i] === 1'b1) begin npulse++; pos = i; end
            total++;
            if (npulse != 1 || pos != n * D) begin
                bad++;
                $display("FAIL tx_done[%0d] data=%h: %0d pulses at %0d, need 1 at %0d", s, d, npulse, pos, n * D);
            end
            total++;
            if (cap_rdy[n * D] !== 1'b0 || cap_rdy[n * D + 1] !== 1'b1 || cap_rdy[n * D / 2] !== 1'b0) begin
                bad++;
                $display("FAIL ready_window[%0d]: mid=%b done=%b after=%b, need 0 0 1",
                         s, cap_rdy[n * D / 2], cap_rdy[n * D], cap_rdy[n * D + 1]);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity(input logic [7:0] d, input logic par);
        bit found;
        start_byte(0, d);
        capture(0, frame_len(0) * D + 4, found);
        total++;
        if (!found || cap_tx[9 * D + D / 2] !== par) begin
            bad++;
            $display("FAIL parity data=%h: got %b, need %b", d, found ? cap_tx[9 * D + D / 2] : 1'bx, par);
        end
    endtask
`endif

    task automatic test_back_to_back();
        bit found;
        bit drv_ok;
        int n, idx, npulse;
        n = frame_len(0);
        drv_ok = 1'b1;
        fork
            begin
                bit seen;
                @(negedge clk);
                tx_data[0]  = 8'h55;
                tx_valid[0] = 1'b1;
                seen = 1'b0;
                for (int i = 0; i < 4 * D && !seen; i++) begin
                    @(negedge clk);
                    if (tx_ready[0] === 1'b0) seen = 1'b1;
                end
                tx_data[0] = 8'hAA;
                seen = 1'b0;
                for (int i = 0; i < 40 * D && !seen; i++) begin
                    @(negedge clk);
                    if (tx_ready[0] === 1'b1) seen = 1'b1;
                end
                if (!seen) drv_ok = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 4 * D && !seen; i++) begin
                    @(negedge clk);
                    if (tx_ready[0] === 1'b0) seen = 1'b1;
                end
                tx_valid[0] = 1'b0;
                tx_data[0]  = 8'($urandom);
            end
            capture(0, (2 * n + 1) * D + 4, found);
        join
        total++;
        if (!found || !drv_ok) begin
            bad++;
            $display("FAIL b2b_handshake: start=%b ready_return=%b, need 1 1", found, drv_ok);
        end else begin
            exp_wave.delete();
            model_frame(0, 8'h55);
            push_bit(1'b1);
            model_frame(0, 8'hAA);
            idx = first_diff();
            if (idx != -1) begin
                bad++;
                $display("FAIL b2b_bits: sample %0d tx=%b, need %b", idx, cap_tx[idx], exp_wave[idx]);
            end
            npulse = 0;
            for (int i = 0; i < cap_done.size(); i++) if (cap_done[i] === 1'b1) npulse++;
            total++;
            if (npulse != 2 || cap_done[n * D] !== 1'b1 || cap_done[(2 * n + 1) * D] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_done: %0d pulses, need 2 at %0d and %0d", npulse, n * D, (2 * n + 1) * D);
            end
            total++;
            if (cap_rdy[n * D] !== 1'b0 || cap_rdy[n * D + 1] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: at done=%b after=%b, need 0 1", cap_rdy[n * D], cap_rdy[n * D + 1]);
            end
        end
    endtask

    task automatic test_coincident_tick();
        int n;
        bit fell;
        @(posedge baud_clk);
        tx_data[0]  = 8'h5A;
        tx_valid[0] = 1'b1;
        n = 0;
        fell = 1'b0;
        while (n < 3 * D && !fell) begin
            @(negedge clk);
            if (n == 0) tx_valid[0] = 1'b0;
            n++;
            if (tx[0] === 1'b0) fell = 1'b1;
        end
        total++;
        if (!fell || n != D + 1) begin
            bad++;
            $display("FAIL coincident_tick: start bit seen after %0d cycles, need %0d", n, D + 1);
        end
        repeat (frame_len(0) * D + 4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit fell;
        int toggles;
        start_byte(0, 8'hF0);
        fell = 1'b0;
        for (int i = 0; i < 4 * D && !fell; i++) begin
            @(negedge clk);
            if (tx[0] === 1'b0) fell = 1'b1;
        end
        repeat (4 * D + D / 2) @(negedge clk);
        total++;
        if (!fell || tx[0] !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_bit3: tx=%b, need 0", tx[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || busy[0] !== 1'b0 || tx_done[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: tx=%b ready=%b busy=%b done=%b, need 1 1 0 0",
                     tx[0], tx_ready[0], busy[0], tx_done[0]);
        end
        toggles = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) toggles++;
        end
        rst_n = 1'b1;
        repeat (3 * D) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) toggles++;
        end
        total++;
        if (toggles != 0) begin
            bad++;
            $display("FAIL abort_quiet: %0d cycles with tx low after reset, need 0", toggles);
        end
        test_frame(0, 8'h3C);
    endtask

    initial begin
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        tx_valid[0] = 1'b0;
        tx_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame(0, 8'hA5);
        test_frame(1, 8'hFF);
`ifdef UART_TX_PARITY_EN
        test_parity(8'hA5, 1'b0);
        test_parity(8'h07, 1'b1);
`endif
        for (int i = 0; i < 4; i++) begin
            test_frame(0, 8'($urandom));
            test_frame(1, 8'($urandom));
        end
        test_back_to_back();
        test_coincident_tick();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
